// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin arbiter for the single register-file write port,
// with a registered write stage and an 8-entry pending-write scoreboard.
// Optional build macro RF_ARB_R0_DISCARD_EN: register 0 reads as zero, so
// writes to it are granted but dropped and reservations of it are ignored.

// One scoreboard entry: a newer reservation beats a completing write.
module rf_wr_sb_bit (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic clr,
   output logic pend_q
);
   // pending flag; set has priority over clear
   always_ff @(posedge clk) begin
      if (rst)      pend_q <= 1'b0;
      else if (set) pend_q <= 1'b1;
      else if (clr) pend_q <= 1'b0;
   end
endmodule

module rf_wr_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [3*NREQ-1:0]    req_dest,
   input  logic [DW*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      gnt,
   output logic [2:0]           dest,
   output logic [DW-1:0]        from_alu,
   output logic                 ld_rf,
   input  logic                 rsv_valid,
   input  logic [2:0]           rsv_dest,
   output logic [7:0]           pend,
   output logic                 rsv_err
);
   localparam int           PW     = (NREQ > 2) ? 2 : 1;
   localparam logic [PW:0]  NREQ_W = (PW+1)'(NREQ);
   localparam logic [PW-1:0] LAST  = PW'(NREQ-1);

   logic [PW-1:0]              ptr;
   logic [PW-1:0]              g_idx;
   logic                       any_gnt;
   logic                       wr_en;
   logic                       rsv_ok;
   logic [NREQ-1:0][2:0]       dest_a;
   logic [NREQ-1:0][DW-1:0]    data_a;

   // split the flat requester buses into per-requester fields
   genvar i;
   generate
      for (i = 0; i < NREQ; i++) begin : g_req
         assign dest_a[i] = req_dest[3*i +: 3];
         assign data_a[i] = req_data[DW*i +: DW];
      end
   endgenerate

   // round-robin scan from ptr; first requesting index wins, nothing while in reset
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      gnt     = '0;
      any_gnt = 1'b0;
      g_idx   = '0;
      sum     = '0;
      idx     = '0;
      if (!rst) begin
         for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= NREQ_W) sum = sum - NREQ_W;
            idx = sum[PW-1:0];
            if (!any_gnt && req[idx]) begin
               any_gnt = 1'b1;
               g_idx   = idx;
            end
         end
         if (any_gnt) gnt[g_idx] = 1'b1;
      end
   end

   // a grant becomes a register-file write unless it targets the zero register
   always_comb begin
`ifdef RF_ARB_R0_DISCARD_EN
      wr_en  = any_gnt && (dest_a[g_idx] != 3'd0);
      rsv_ok = rsv_valid && (rsv_dest != 3'd0);
`else
      wr_en  = any_gnt;
      rsv_ok = rsv_valid;
`endif
   end

   // pointer moves just past the winner; holds when nobody is granted
   always_ff @(posedge clk) begin
      if (rst)          ptr <= '0;
      else if (any_gnt) ptr <= (g_idx == LAST) ? '0 : g_idx + PW'(1);
   end

   // registered write stage; dest/data hold when no write is issued
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_rf    <= 1'b0;
         dest     <= '0;
         from_alu <= '0;
      end else begin
         ld_rf <= wr_en;
         if (wr_en) begin
            dest     <= dest_a[g_idx];
            from_alu <= data_a[g_idx];
         end
      end
   end

   // scoreboard: one entry per architectural register
   genvar d;
   generate
      for (d = 0; d < 8; d++) begin : g_sb
         rf_wr_sb_bit u_sb (
            .clk    (clk),
            .rst    (rst),
            .set    (rsv_ok && (rsv_dest == 3'(d))),
            .clr    (ld_rf && (dest == 3'(d))),
            .pend_q (pend[d])
         );
      end
   endgenerate

   // flag a reservation of a register still pending and not retiring this cycle
   always_ff @(posedge clk) begin
      if (rst) rsv_err <= 1'b0;
      else     rsv_err <= rsv_ok && pend[rsv_dest] && !(ld_rf && (dest == rsv_dest));
   end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single write port of the 8x16-bit register file among NREQ write requesters, for example ALU result, load return and immediate move.
- Round-robin arbitration; the winning write is registered and driven onto the register file's dest / from_alu / ld_rf inputs one cycle later.
- Keeps an 8-entry pending-write scoreboard so the issue logic can detect RAW/WAW hazards on registers with an outstanding write.

Parameters:
- NREQ, 3, number of write requesters (legal range 2..4).
- DW, 16, data width; must equal the register file word width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester write request; held until granted.
- req_dest  input  3*NREQ  destination register index for each requester; requester i uses bits [3i+2:3i].
- req_data  input  DW*NREQ  write data for each requester; requester i uses bits [DWi+DW-1:DWi].
- gnt  output  NREQ  combinational one-hot grant; the write is accepted in the cycle gnt[i]=1.
- dest  output  3  register file write index (registered).
- from_alu  output  DW  register file write data (registered).
- ld_rf  output  1  register file write enable (registered).
- rsv_valid  input  1  reserve the register at rsv_dest as pending, issued by decode.
- rsv_dest  input  3  index of the register to reserve.
- pend  output  8  scoreboard; bit d=1 means a write to register d is outstanding.
- rsv_err  output  1  one-cycle registered pulse when a reservation targets a register that is already pending.

Behaviour:
- Reset (rst=1 at a clk edge):
  - ld_rf=0, dest=0, from_alu=0.
  - pend=8'h00, rsv_err=0.
  - Round-robin pointer ptr=0.
  - While rst is high, gnt is forced to 0. Any write in flight is dropped and not replayed.
- Arbitration, combinational:
  - Scan req starting at index ptr, wrapping modulo NREQ.
  - The first set bit wins; gnt is one-hot or all zero.
  - No idle or back-pressure state: a requester is always granted when it wins the scan.
- Pointer update:
  - On any grant to index g, ptr <= (g+1) mod NREQ at the next edge.
  - With no grant, ptr holds its value.
- Output stage:
  - If some gnt[g]=1, at the next edge: ld_rf<=1, dest<=req_dest[g], from_alu<=req_data[g].
  - Otherwise ld_rf<=0; dest and from_alu hold their previous values.
  - Latency is exactly 1 cycle from acceptance to ld_rf. Throughput is 1 write per cycle.
- Handshake:
  - A requester holds req, req_dest and req_data stable until it sees gnt.
  - It may drop or change them the cycle after the grant.
  - A requester that drops req before being granted is legal; nothing is written for it.
- Fairness: with all requesters continuously active, each is granted once every NREQ cycles.
- Scoreboard, updated at each edge:
  - Set: if rsv_valid, pend[rsv_dest]<=1.
  - Clear: if ld_rf==1 in the current cycle, pend[dest]<=0.
  - Set and clear of the same bit in the same cycle: set wins, because the newer reservation survives.
  - Set and clear of different bits in the same cycle: both take effect.
- rsv_err:
  - rsv_err<=1 when rsv_valid and pend[rsv_dest] was already 1 and is not being cleared in the same cycle.
  - Otherwise rsv_err<=0.
  - It is a pulse only and does not block the reservation.
- A write to a register that is not pending is legal: ld_rf asserts and the clear has no effect.
- Simultaneous req and rsv_valid on unrelated registers are independent.

Optional Feature:
- Macro: RF_ARB_R0_DISCARD_EN.
- Defined: register 0 is hard-wired zero.
  - A granted request with req_dest==0 still receives gnt and advances ptr.
  - ld_rf stays 0 the next cycle, and dest / from_alu hold their previous values.
  - rsv_valid with rsv_dest==0 is ignored: pend[0] stays 0 and rsv_err never fires for register 0.
- Undefined: register 0 is treated like any other register.

Test Plan:
- Reset: assert rst for 2 cycles with all req=1 -> gnt=0 throughout; after release ld_rf=0, pend=00, and the first grant goes to requester 0.
- Single write: req=3'b010, req_dest[1]=5, req_data[1]=16'hBEEF -> gnt=3'b010 in that cycle; next cycle ld_rf=1, dest=5, from_alu=BEEF; the cycle after, ld_rf=0.
- Round-robin: hold req=3'b111 for 6 cycles -> grant sequence 0,1,2,0,1,2; ld_rf=1 on each of the 6 following cycles.
- Scoreboard: rsv 3 -> pend=08; a later requester write to 3 -> pend=00 one edge after ld_rf; rsv 3 in the same cycle ld_rf writes dest 3 -> pend stays 08 and rsv_err=0.
- Double reservation: rsv 6 twice on back-to-back cycles -> rsv_err=1 for exactly one cycle after the second reservation; pend=40.
- With RF_ARB_R0_DISCARD_EN: req_dest=0 granted -> gnt pulses, ld_rf stays 0, ptr advances; rsv 0 -> pend stays 00. Without the macro: ld_rf=1 and dest=0.
